// File: rtl/branch_rs_scheduler_if.sv
// Dispatch, CDB, ROB-head and branch-FU issue signals for the branch reservation station.
// master = dispatch/CDB/FU side, slave = the station itself.
interface branch_rs_scheduler_if #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_SIZE      = 256,
    parameter int unsigned UOP_SIZE      = 16,
    parameter int unsigned PHYS_REG_SIZE = 256,
    parameter int unsigned RS_DEPTH      = 4
);
    localparam int unsigned ROBW = $clog2(ROB_SIZE);
    localparam int unsigned UOPW = $clog2(UOP_SIZE);
    localparam int unsigned PRW  = $clog2(PHYS_REG_SIZE);
    localparam int unsigned CNTW = $clog2(RS_DEPTH) + 1;

    logic            flush;
    logic            disp_valid;
    logic            disp_ready;
    logic [UOPW-1:0] disp_uop;
    logic            disp_rs1_rdy;
    logic [PRW-1:0]  disp_rs1_tag;
    logic [XLEN-1:0] disp_rs1_val;
    logic            disp_rs2_rdy;
    logic [PRW-1:0]  disp_rs2_tag;
    logic [XLEN-1:0] disp_rs2_val;
    logic [XLEN-1:0] disp_pc;
    logic [XLEN-1:0] disp_offset;
    logic [ROBW-1:0] disp_rob_entry;
    logic [PRW-1:0]  disp_dest_tag;
    logic [ROBW-1:0] rob_head;
    logic            cdb_valid;
    logic [PRW-1:0]  cdb_tag;
    logic [XLEN-1:0] cdb_data;
    logic            fu_valid;
    logic [UOPW-1:0] fu_uop;
    logic [XLEN-1:0] fu_rs1;
    logic [XLEN-1:0] fu_rs2;
    logic [XLEN-1:0] fu_pc;
    logic [XLEN-1:0] fu_offset;
    logic [ROBW-1:0] fu_rob_entry;
    logic [PRW-1:0]  fu_dest_tag;
    logic [CNTW-1:0] rs_count;

    modport master (
        output flush, disp_valid, disp_uop, disp_rs1_rdy, disp_rs1_tag, disp_rs1_val,
               disp_rs2_rdy, disp_rs2_tag, disp_rs2_val, disp_pc, disp_offset,
               disp_rob_entry, disp_dest_tag, rob_head, cdb_valid, cdb_tag, cdb_data,
        input  disp_ready, fu_valid, fu_uop, fu_rs1, fu_rs2, fu_pc, fu_offset,
               fu_rob_entry, fu_dest_tag, rs_count
    );

    modport slave (
        input  flush, disp_valid, disp_uop, disp_rs1_rdy, disp_rs1_tag, disp_rs1_val,
               disp_rs2_rdy, disp_rs2_tag, disp_rs2_val, disp_pc, disp_offset,
               disp_rob_entry, disp_dest_tag, rob_head, cdb_valid, cdb_tag, cdb_data,
        output disp_ready, fu_valid, fu_uop, fu_rs1, fu_rs2, fu_pc, fu_offset,
               fu_rob_entry, fu_dest_tag, rs_count
    );
endinterface

// File: rtl/branch_rs_scheduler.sv
// Branch-FU reservation station: captures operands from the CDB and issues the oldest
// ready uop (by ROB distance from head) each cycle. Flush clears everything.
module branch_rs_scheduler #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_SIZE      = 256,
    parameter int unsigned UOP_SIZE      = 16,
    parameter int unsigned PHYS_REG_SIZE = 256,
    parameter int unsigned RS_DEPTH      = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    branch_rs_scheduler_if.slave  bus
);
    localparam int unsigned ROBW = $clog2(ROB_SIZE);
    localparam int unsigned UOPW = $clog2(UOP_SIZE);
    localparam int unsigned PRW  = $clog2(PHYS_REG_SIZE);
    localparam int unsigned IDXW = $clog2(RS_DEPTH);
    localparam int unsigned CNTW = IDXW + 1;

    typedef struct packed {
        logic [UOPW-1:0] uop;
        logic            rs1_rdy;
        logic [PRW-1:0]  rs1_tag;
        logic [XLEN-1:0] rs1_val;
        logic            rs2_rdy;
        logic [PRW-1:0]  rs2_tag;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] offset;
        logic [ROBW-1:0] rob;
        logic [PRW-1:0]  dest;
    } entry_t;

    typedef struct packed {
        logic [UOPW-1:0] uop;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] offset;
        logic [ROBW-1:0] rob;
        logic [PRW-1:0]  dest;
    } issue_t;

    entry_t              ent_q [RS_DEPTH];
    entry_t              ent_d [RS_DEPTH];
    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                fu_valid_q, fu_valid_d;
    issue_t              fu_q, fu_d;

    logic            free_found;
    logic [IDXW-1:0] free_idx;
    logic            sel_found;
    logic [IDXW-1:0] sel_idx;
    logic [ROBW-1:0] sel_age;
    logic [ROBW-1:0] age;
    logic            disp_ready;
    logic            accept;
    logic            issue;
    entry_t          new_ent;

    // Ready comes from the registered count only, so a slot freed by issue waits a cycle.
    assign disp_ready = (count_q < CNTW'(RS_DEPTH)) && !bus.flush;
    assign accept     = bus.disp_valid && disp_ready;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        age        = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDXW'(i);
            end
            age = ent_q[i].rob - bus.rob_head;
            // Strict compare keeps the lower index on an age tie.
            if (valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy &&
                (!sel_found || age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(i);
                sel_age   = age;
            end
        end
    end

    assign issue = sel_found && !bus.flush;

    always_comb begin
        new_ent.uop     = bus.disp_uop;
        new_ent.rs1_tag = bus.disp_rs1_tag;
        new_ent.rs1_rdy = bus.disp_rs1_rdy ||
                          (bus.cdb_valid && bus.cdb_tag == bus.disp_rs1_tag);
        new_ent.rs1_val = bus.disp_rs1_rdy ? bus.disp_rs1_val : bus.cdb_data;
        new_ent.rs2_tag = bus.disp_rs2_tag;
        new_ent.rs2_rdy = bus.disp_rs2_rdy ||
                          (bus.cdb_valid && bus.cdb_tag == bus.disp_rs2_tag);
        new_ent.rs2_val = bus.disp_rs2_rdy ? bus.disp_rs2_val : bus.cdb_data;
        new_ent.pc      = bus.disp_pc;
        new_ent.offset  = bus.disp_offset;
        new_ent.rob     = bus.disp_rob_entry;
        new_ent.dest    = bus.disp_dest_tag;
    end

    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_q[i] && bus.cdb_valid) begin
                if (!ent_q[i].rs1_rdy && ent_q[i].rs1_tag == bus.cdb_tag) begin
                    ent_d[i].rs1_rdy = 1'b1;
                    ent_d[i].rs1_val = bus.cdb_data;
                end
                if (!ent_q[i].rs2_rdy && ent_q[i].rs2_tag == bus.cdb_tag) begin
                    ent_d[i].rs2_rdy = 1'b1;
                    ent_d[i].rs2_val = bus.cdb_data;
                end
            end
        end
        if (issue) valid_d[sel_idx] = 1'b0;
        if (accept) begin
            ent_d[free_idx]   = new_ent;
            valid_d[free_idx] = 1'b1;
        end
        count_d    = count_q + CNTW'(accept) - CNTW'(issue);
        fu_valid_d = issue;
        fu_d       = fu_q;
        if (issue) begin
            fu_d.uop    = ent_q[sel_idx].uop;
            fu_d.rs1    = ent_q[sel_idx].rs1_val;
            fu_d.rs2    = ent_q[sel_idx].rs2_val;
            fu_d.pc     = ent_q[sel_idx].pc;
            fu_d.offset = ent_q[sel_idx].offset;
            fu_d.rob    = ent_q[sel_idx].rob;
            fu_d.dest   = ent_q[sel_idx].dest;
        end
        if (bus.flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            count_q    <= '0;
            fu_valid_q <= 1'b0;
            fu_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            count_q    <= count_d;
            fu_valid_q <= fu_valid_d;
            fu_q       <= fu_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        ent_q <= ent_d;
    end

    assign bus.disp_ready   = disp_ready;
    assign bus.rs_count     = count_q;
    assign bus.fu_valid     = fu_valid_q;
    assign bus.fu_uop       = fu_q.uop;
    assign bus.fu_rs1       = fu_q.rs1;
    assign bus.fu_rs2       = fu_q.rs2;
    assign bus.fu_pc        = fu_q.pc;
    assign bus.fu_offset    = fu_q.offset;
    assign bus.fu_rob_entry = fu_q.rob;
    assign bus.fu_dest_tag  = fu_q.dest;
endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Bench for branch_rs_scheduler: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the station.
module tb_branch_rs_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_rs_scheduler_if #(
        .XLEN(32), .ROB_SIZE(256), .UOP_SIZE(16), .PHYS_REG_SIZE(256), .RS_DEPTH(4)
    ) ifc ();

    branch_rs_scheduler #(
        .XLEN(32), .ROB_SIZE(256), .UOP_SIZE(16), .PHYS_REG_SIZE(256), .RS_DEPTH(4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    typedef struct {
        logic [3:0]  uop;
        logic        r1;
        logic [7:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [7:0]  t2;
        logic [31:0] v2;
        logic [31:0] pc;
        logic [31:0] off;
        logic [7:0]  rob;
        logic [7:0]  dest;
    } ment_t;

    ment_t       mq[$];
    logic        e_fv;
    ment_t       e_fu;
    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drv_idle();
        rst            = 1'b0;
        ifc.flush      = 1'b0;
        ifc.disp_valid = 1'b0;
        ifc.cdb_valid  = 1'b0;
    endtask

    task automatic drv_disp(input logic [3:0] uop, input logic r1, input logic [7:0] t1,
                            input logic [31:0] v1, input logic r2, input logic [7:0] t2,
                            input logic [31:0] v2, input logic [7:0] rob);
        ifc.disp_valid     = 1'b1;
        ifc.disp_uop       = uop;
        ifc.disp_rs1_rdy   = r1;
        ifc.disp_rs1_tag   = t1;
        ifc.disp_rs1_val   = v1;
        ifc.disp_rs2_rdy   = r2;
        ifc.disp_rs2_tag   = t2;
        ifc.disp_rs2_val   = v2;
        ifc.disp_pc        = 32'h1000 + 32'(rob) * 4;
        ifc.disp_offset    = {24'hFFFFFF, rob};
        ifc.disp_rob_entry = rob;
        ifc.disp_dest_tag  = rob ^ 8'h5A;
    endtask

    task automatic drv_cdb(input logic [7:0] tag, input logic [31:0] data);
        ifc.cdb_valid = 1'b1;
        ifc.cdb_tag   = tag;
        ifc.cdb_data  = data;
    endtask

    // Model: the station is an unordered bag of uops; the oldest ready one by ROB distance leaves.
    task automatic model_edge(input logic acc);
        int    best;
        int    best_age;
        int    a;
        ment_t n;
        if (rst) begin
            mq.delete();
            e_fv = 1'b0;
            e_fu = '{default: '0};
            return;
        end
        if (ifc.flush) begin
            mq.delete();
            e_fv = 1'b0;
            return;
        end
        best     = -1;
        best_age = 0;
        foreach (mq[i]) begin
            if (mq[i].r1 && mq[i].r2) begin
                a = (int'(mq[i].rob) - int'(ifc.rob_head) + 256) % 256;
                if (best < 0 || a < best_age) begin
                    best     = i;
                    best_age = a;
                end
            end
        end
        e_fv = (best >= 0);
        if (best >= 0) e_fu = mq[best];
        if (ifc.cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].r1 && mq[i].t1 == ifc.cdb_tag) begin
                    mq[i].r1 = 1'b1;
                    mq[i].v1 = ifc.cdb_data;
                end
                if (!mq[i].r2 && mq[i].t2 == ifc.cdb_tag) begin
                    mq[i].r2 = 1'b1;
                    mq[i].v2 = ifc.cdb_data;
                end
            end
        end
        if (best >= 0) mq.delete(best);
        if (acc) begin
            n.uop  = ifc.disp_uop;
            n.t1   = ifc.disp_rs1_tag;
            n.t2   = ifc.disp_rs2_tag;
            n.r1   = ifc.disp_rs1_rdy || (ifc.cdb_valid && ifc.cdb_tag == n.t1);
            n.v1   = ifc.disp_rs1_rdy ? ifc.disp_rs1_val : ifc.cdb_data;
            n.r2   = ifc.disp_rs2_rdy || (ifc.cdb_valid && ifc.cdb_tag == n.t2);
            n.v2   = ifc.disp_rs2_rdy ? ifc.disp_rs2_val : ifc.cdb_data;
            n.pc   = ifc.disp_pc;
            n.off  = ifc.disp_offset;
            n.rob  = ifc.disp_rob_entry;
            n.dest = ifc.disp_dest_tag;
            mq.push_back(n);
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        logic exp_ready;
        #1;
        exp_ready = (mq.size() < 4) && !ifc.flush;
        if (!rst) begin
            check_eq("disp_ready", ifc.disp_ready, exp_ready);
            check_eq("rs_count", ifc.rs_count, mq.size());
        end
        model_edge(ifc.disp_valid && exp_ready && !rst);
        @(posedge clk);
        #1;
        check_eq("fu_valid", ifc.fu_valid, e_fv);
        check_eq("fu_uop", ifc.fu_uop, e_fu.uop);
        check_eq("fu_rs1", ifc.fu_rs1, e_fu.v1);
        check_eq("fu_rs2", ifc.fu_rs2, e_fu.v2);
        check_eq("fu_pc", ifc.fu_pc, e_fu.pc);
        check_eq("fu_offset", ifc.fu_offset, e_fu.off);
        check_eq("fu_rob_entry", ifc.fu_rob_entry, e_fu.rob);
        check_eq("fu_dest_tag", ifc.fu_dest_tag, e_fu.dest);
        drv_idle();
    endtask

    initial begin
        logic [7:0] rob;
        logic       dup;
        e_fv = 1'b0;
        e_fu = '{default: '0};
        ifc.rob_head = 8'd0;
        ifc.cdb_tag  = '0;
        ifc.cdb_data = '0;
        drv_disp(4'd0, 1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0, 8'd0);
        drv_idle();
        rst = 1'b1;
        @(posedge clk);
        step();
        step();

        // Both operands ready at dispatch: issue two cycles later.
        drv_disp(4'd1, 1'b1, 8'd1, 32'd5, 1'b1, 8'd2, 32'd5, 8'd3);
        step();
        check_eq("t1_not_yet", ifc.fu_valid, 1'b0);
        step();
        check_eq("t1_rob", ifc.fu_rob_entry, 8'd3);
        check_eq("t1_rs1", ifc.fu_rs1, 32'd5);
        step();

        // Late CDB wakeup.
        drv_disp(4'd2, 1'b0, 8'd17, 32'd0, 1'b1, 8'd3, 32'd7, 8'd4);
        step();
        step();
        step();
        drv_cdb(8'd17, 32'hDEAD);
        step();
        step();
        check_eq("t2_rs1", ifc.fu_rs1, 32'hDEAD);
        step();

        // Wrapped ROB ages, head 250: rob 2 is older than rob 10 once both wake together.
        ifc.rob_head = 8'd250;
        drv_disp(4'd3, 1'b0, 8'd30, 32'd0, 1'b1, 8'd0, 32'd1, 8'd10);
        step();
        drv_disp(4'd3, 1'b0, 8'd30, 32'd0, 1'b1, 8'd0, 32'd2, 8'd2);
        step();
        drv_cdb(8'd30, 32'h30);
        step();
        step();
        check_eq("t3_first", ifc.fu_rob_entry, 8'd2);
        step();
        check_eq("t3_second", ifc.fu_rob_entry, 8'd10);
        step();

        // Fill the station, then free one slot via wakeup.
        ifc.rob_head = 8'd0;
        for (int i = 0; i < 4; i++) begin
            drv_disp(4'd4, 1'b0, 8'(20 + i), 32'd0, 1'b1, 8'd0, 32'd9, 8'(40 + i));
            step();
        end
        check_eq("t4_full_cnt", ifc.rs_count, 3'd4);
        check_eq("t4_full_rdy", ifc.disp_ready, 1'b0);
        drv_cdb(8'd20, 32'h20);
        step();
        drv_disp(4'd4, 1'b1, 8'd0, 32'd1, 1'b1, 8'd0, 32'd1, 8'd50);
        step();
        check_eq("t4_issued", ifc.fu_rob_entry, 8'd40);
        step();

        // Flush with a dispatch pending; flushed uops never issue.
        drv_disp(4'd5, 1'b1, 8'd0, 32'd1, 1'b1, 8'd0, 32'd1, 8'd60);
        ifc.flush = 1'b1;
        step();
        check_eq("t5_cnt", ifc.rs_count, 3'd0);
        for (int i = 0; i < 3; i++) begin
            drv_cdb(8'(21 + i), 32'h77);
            step();
        end
        step();
        step();

        // Dispatch coinciding with the matching CDB broadcast.
        drv_disp(4'd6, 1'b1, 8'd0, 32'd3, 1'b0, 8'd9, 32'd0, 8'd70);
        drv_cdb(8'd9, 32'h40);
        step();
        step();
        check_eq("t6_rs2", ifc.fu_rs2, 32'h40);
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) ifc.rob_head = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rob = ifc.rob_head + 8'($urandom_range(0, 60));
                dup = 1'b0;
                foreach (mq[i]) if (mq[i].rob == rob) dup = 1'b1;
                if (!dup) drv_disp(4'($urandom), 1'($urandom), 8'($urandom_range(0, 7)),
                                   $urandom, 1'($urandom), 8'($urandom_range(0, 7)),
                                   $urandom, rob);
            end
            if ($urandom_range(0, 1) == 1) drv_cdb(8'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 39) == 0) ifc.flush = 1'b1;
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
